// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word per instruction over
// a req/ack handshake and issues it to the decoder and datapath.
//
// state | meaning
// REQ   | request outstanding at pc, waiting for inst_ack
// ISSUE | instruction presented on inst/pc_out, waiting for consumer
// DRAIN | redirected while a request was in flight; swallow its ack
// HALT  | control unit halted; idle until reset
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halted,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc_out,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        halt_state
);

  typedef enum logic [1:0] {S_REQ, S_ISSUE, S_DRAIN, S_HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] redir_target;
  logic        unused_redir_bits;

  assign redir_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redir_bits = ^redirect_pc[1:0];

  // DRAIN keeps presenting the abandoned address so the memory sees a stable request
  assign inst_req  = (state == S_REQ) || (state == S_DRAIN);
  assign inst_addr = (state == S_DRAIN) ? drain_addr : pc;
  assign opcode    = inst[31:26];
  assign func      = inst[5:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      inst       <= 32'h0;
      pc_out     <= 32'h0;
      inst_valid <= 1'b0;
      halt_state <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (halted) begin
            state      <= S_HALT;
            inst_valid <= 1'b0;
            halt_state <= 1'b1;
          end else if (redirect_valid) begin
            pc <= redir_target;
            if (!inst_ack) begin
              drain_addr <= pc;
              state      <= S_DRAIN;
            end
          end else if (inst_ack) begin
            inst       <= inst_rdata;
            pc_out     <= pc;
            pc         <= pc + 32'd4;
            inst_valid <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (halted) begin
            state      <= S_HALT;
            inst_valid <= 1'b0;
            halt_state <= 1'b1;
          end else if (redirect_valid) begin
            pc         <= redir_target;
            inst_valid <= 1'b0;
            state      <= S_REQ;
          end else if (!stall) begin
            inst_valid <= 1'b0;
            state      <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (halted) begin
            state      <= S_HALT;
            halt_state <= 1'b1;
          end else begin
            if (redirect_valid) pc <= redir_target;
            if (inst_ack) state <= S_REQ;
          end
        end
        default: begin
          state      <= S_HALT;
          inst_valid <= 1'b0;
          halt_state <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed handshake/redirect/halt cases followed by
// randomized traffic checked against a transaction-level instruction-stream model.
module tb_inst_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc_out;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        halt_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_b(rst_b), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_ack(inst_ack), .inst_rdata(inst_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
    .inst(inst), .inst_valid(inst_valid), .pc_out(pc_out), .opcode(opcode),
    .func(func), .halt_state(halt_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // instruction memory contents as a pure function of address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h0019_660D) ^ 32'h3C6E_F35F;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_in();
    inst_ack = 1'b0; inst_rdata = 32'h0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; halted = 1'b0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    clr_in();
    tick();
    rst_b = 1'b1;
  endtask

  logic [31:0] exp_pc, p_addr, p_inst, p_pcout, p_target, a;
  logic        p_valid, p_req, p_ack, p_stall, p_redir;
  int          issued;

  initial begin
    clr_in();
    rst_b = 1'b0;
    tick();
    chk("rst_req",   inst_req,   1);
    chk("rst_addr",  inst_addr,  RPC);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pcout", pc_out,     0);
    chk("rst_inst",  inst,       0);
    chk("rst_halt",  halt_state, 0);
    rst_b = 1'b1;

    // back-to-back fetch with immediate ack
    for (int k = 0; k < 3; k++) begin
      a = 32'(RPC + 4 * k);
      chk("t1_req",   inst_req,   1);
      chk("t1_addr",  inst_addr,  a);
      chk("t1_idle",  inst_valid, 0);
      inst_ack = 1'b1; inst_rdata = mem(a);
      tick();
      inst_ack = 1'b0;
      chk("t1_valid", inst_valid, 1);
      chk("t1_pcout", pc_out,     a);
      chk("t1_inst",  inst,       mem(a));
      chk("t1_noreq", inst_req,   0);
      tick();
    end

    // slow memory: address held across wait cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("t2_req",  inst_req,  1);
      chk("t2_addr", inst_addr, RPC);
      if (i == 3) begin inst_ack = 1'b1; inst_rdata = 32'h2008_0005; end
      tick();
    end
    inst_ack = 1'b0;
    chk("t2_valid",  inst_valid, 1);
    chk("t2_inst",   inst,       32'h2008_0005);
    chk("t2_opcode", opcode,     6'h08);
    chk("t2_func",   func,       6'h05);

    // consumer stall holds the issued instruction
    stall = 1'b1;
    repeat (4) begin
      tick();
      chk("t3_valid", inst_valid, 1);
      chk("t3_inst",  inst,       32'h2008_0005);
      chk("t3_pcout", pc_out,     RPC);
      chk("t3_noreq", inst_req,   0);
    end
    stall = 1'b0;
    tick();
    chk("t3_idle", inst_valid, 0);
    chk("t3_req",  inst_req,   1);
    chk("t3_addr", inst_addr,  32'h44);

    // redirect while request outstanding: drain then refetch at target
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    chk("t4_req",   inst_req,   1);
    chk("t4_hold",  inst_addr,  32'h44);
    chk("t4_idle",  inst_valid, 0);
    tick();
    chk("t4_hold2", inst_addr,  32'h44);
    inst_ack = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    tick();
    inst_ack = 1'b0;
    chk("t4_drop",  inst_valid, 0);
    chk("t4_req2",  inst_req,   1);
    chk("t4_tgt",   inst_addr,  32'h100);
    inst_ack = 1'b1; inst_rdata = mem(32'h100);
    tick();
    inst_ack = 1'b0;
    chk("t4_valid", inst_valid, 1);
    chk("t4_pcout", pc_out,     32'h100);
    chk("t4_inst",  inst,       mem(32'h100));
    tick();
    chk("t4_next",  inst_addr,  32'h104);

    // redirect coinciding with ack
    inst_ack = 1'b1; inst_rdata = mem(32'h104);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    clr_in();
    chk("t5_drop",  inst_valid, 0);
    chk("t5_req",   inst_req,   1);
    chk("t5_tgt",   inst_addr,  32'h200);
    inst_ack = 1'b1; inst_rdata = mem(32'h200);
    tick();
    inst_ack = 1'b0;
    chk("t5_valid", inst_valid, 1);
    chk("t5_pcout", pc_out,     32'h200);

    // halt from ISSUE; sticky until reset, stray acks ignored
    halted = 1'b1;
    tick();
    halted = 1'b0;
    chk("t6_halt",  halt_state, 1);
    chk("t6_noreq", inst_req,   0);
    chk("t6_idle",  inst_valid, 0);
    repeat (10) begin
      inst_ack = 1'($urandom % 2); inst_rdata = $urandom;
      tick();
      chk("t6_halt_h",  halt_state, 1);
      chk("t6_noreq_h", inst_req,   0);
      chk("t6_idle_h",  inst_valid, 0);
    end
    #2 rst_b = 1'b0;
    #1;
    chk("t6_rst_req",  inst_req,   1);
    chk("t6_rst_addr", inst_addr,  RPC);
    chk("t6_rst_halt", halt_state, 0);
    chk("t6_rst_pc",   pc_out,     0);
    clr_in();
    tick();
    rst_b = 1'b1;

    // randomized traffic against the instruction-stream model
    exp_pc = RPC;
    issued = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) begin
        if (p_redir) begin
          chk("rnd_redir_kill", inst_valid, 0);
          exp_pc = {p_target[31:2], 2'b00};
        end else if (inst_valid && !p_valid) begin
          chk("rnd_pcout",  pc_out, exp_pc);
          chk("rnd_inst",   inst,   mem(exp_pc));
          chk("rnd_opcode", opcode, 32'(mem(exp_pc) >> 26));
          chk("rnd_func",   func,   32'(mem(exp_pc) & 32'h3F));
          exp_pc = exp_pc + 32'd4;
          issued++;
        end
        if (p_valid && p_stall && !p_redir) begin
          chk("rnd_stall_v",  inst_valid, 1);
          chk("rnd_stall_i",  inst,       p_inst);
          chk("rnd_stall_pc", pc_out,     p_pcout);
        end
        if (p_valid && !p_stall && !p_redir) begin
          chk("rnd_consume_v", inst_valid, 0);
          chk("rnd_consume_r", inst_req,   1);
        end
        if (p_req && !p_ack) begin
          chk("rnd_req_hold", inst_req,  1);
          chk("rnd_addr_hold", inst_addr, p_addr);
        end
      end
      p_valid = inst_valid; p_req = inst_req; p_addr = inst_addr;
      p_inst = inst; p_pcout = pc_out;
      inst_ack   = inst_req && ($urandom % 3 == 0);
      inst_rdata = inst_ack ? mem(inst_addr) : $urandom;
      stall      = 1'($urandom % 2);
      redirect_valid = ($urandom % 10 == 0);
      redirect_pc    = ($urandom % 8 == 0) ? 32'hFFFF_FFFD : $urandom;
      p_ack = inst_ack; p_stall = stall; p_redir = redirect_valid;
      p_target = redirect_pc;
      tick();
    end
    clr_in();
    chk("rnd_progress", 32'(issued > 100), 1);
    halted = 1'b1;
    tick();
    chk("end_halt", halt_state, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
